sc_rr_slave_port_arbiter: RTL
=============================

// Module: sc_rr_slave_port_arbiter
// PURPOSE
// - Per-slave round-robin arbiter for the crossbar: owns one slave port, picks one of N masters whose
//   address decodes to this slave, holds that grant until the slave acks, then rotates priority.
// - One instance per slave; its one-hot o_grant drives the crossbar matrix select for that slave.
// PARAMETERS
// - N_MASTERS   2            number of requesting masters (2..8)
// - SL_BASE     32'h00000000 slave address window base; compared after masking
// - SL_MASK     32'h80000000 address bits that select this slave
// - TIMEOUT     256          cycles in GRANT without ack before forced release (watchdog only)
// PORTS
// - i_clk         in   1              clock, all state on rising edge
// - i_resetb      in   1              asynchronous active-low reset
// - i_ms_req      in   N_MASTERS      per-master request level, held until ack
// - i_ms_addr     in   32*N_MASTERS   per-master address, master k in bits [32k+31:32k]
// - i_sl_ack      in   1              slave single-cycle ack ending the current transfer
// - o_grant       out  N_MASTERS      one-hot grant, all-zero when idle
// - o_grant_idx   out  clog2(N)       binary index of granted master, valid while o_busy
// - o_busy        out  1              slave port owned by a master
// - o_timeout     out  1              one-cycle pulse: watchdog forced release
// BEHAVIOUR
// - Reset (async, i_resetb=0): o_grant=0, o_grant_idx=0, o_busy=0, o_timeout=0, pointer=0, FSM=IDLE;
//   mid-transfer reset drops grant immediately, no ack is fabricated.
// - Eligible(k) = i_ms_req[k] && ((i_ms_addr[k] & SL_MASK) == SL_BASE); non-decoding requests ignored.
// - FSM IDLE: on edge with any eligible master -> GRANT, latch winner; o_grant/o_busy high from next cycle.
// - Winner: first eligible master searching from pointer upward, wrapping N_MASTERS-1 -> 0.
// - FSM GRANT: grant frozen; request/address changes of other masters have no effect.
//   - i_sl_ack=1 at edge -> IDLE, pointer = winner+1 (mod N_MASTERS), o_grant=0 next cycle.
//   - granted i_ms_req low at edge without ack (abort) -> IDLE, pointer = winner+1, no o_timeout.
//   - ack and abort same edge -> treated as ack.
// - i_sl_ack while IDLE ignored (no state change).
// - Latency: req to grant 1 cycle; ack to next possible grant 1 cycle (one IDLE cycle between
//   transfers, so the acked master's still-high req is never re-sampled).
// - Single requester re-requesting gets every slot; N contending masters each served once per N transfers.
// CONFIGURATION
// - SC_RR_ARB_TIMEOUT_EN defined: counter (clog2(TIMEOUT+1) bits) cleared on entering GRANT,
//   +1 per GRANT cycle; at TIMEOUT-1 with no ack -> IDLE, o_timeout=1 for one cycle, pointer=winner+1.
//   Ack on the same edge wins (no o_timeout).
// - Not defined: no counter, o_timeout tied 0, GRANT held indefinitely until ack/abort.
// STRUCTURE
// - sc_rr_crossbar_defs.vh: SC_ADDR_W=32, FSM state encodings (IDLE=1'b0, GRANT=1'b1),
//   default slave base/mask constants shared by all slave-port instances.
// - Sub-module sc_rr_prio_picker: combinational rotate-priority one-hot/index picker
//   (eligible vector + pointer -> winner); reused by any future master-side arbiter.
// TESTING
// - Reset: N=2, drive reqs, pulse i_resetb low mid-GRANT -> o_grant=00, o_busy=0 same cycle.
// - Single master: m0 req addr 0x0000_0010 -> o_grant=01 next cycle; ack after 3 cycles -> 00, 1 idle cycle.
// - Contention: m0,m1 both req addr 0x10 continuously, ack every grant -> grants alternate 01,10,01,10.
// - Decode: m1 req addr 0x8000_0000 (SL_BASE=0) -> never granted; m0 addr 0x4 granted normally.
// - Abort: m1 granted, drops req with no ack -> IDLE next cycle, pointer=0, o_timeout stays 0.
// - Watchdog (SC_RR_ARB_TIMEOUT_EN, TIMEOUT=8): grant m0, no ack -> o_timeout pulse 8 cycles after
//   grant, o_grant=00; ack on cycle 8 instead -> no pulse.

Source files
------------

// File: rtl/sc_rr_slave_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sc_rr_slave_port_arbiter_pkg
// Shared crossbar definitions for the slave-port arbiters:
//   - SC_ADDR_W        : address width of every master port
//   - SC_DEF_SL_BASE   : default slave window base (compared after masking)
//   - SC_DEF_SL_MASK   : default address bits that select a slave
//   - sc_arb_state_t   : arbiter FSM state encoding (IDLE=0, GRANT=1)
//   - sc_wrap_idx      : (base + off) mod n for 0 <= base, off < n
// -----------------------------------------------------------------------------
package sc_rr_slave_port_arbiter_pkg;

   localparam int          SC_ADDR_W      = 32;
   localparam logic [31:0] SC_DEF_SL_BASE = 32'h0000_0000;
   localparam logic [31:0] SC_DEF_SL_MASK = 32'h8000_0000;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } sc_arb_state_t;

   // Both operands are already below n, so one conditional subtract suffices.
   function automatic int sc_wrap_idx(input int base, input int off, input int n);
      int s;
      s = base + off;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/sc_rr_slave_port_arbiter_prio_picker.sv
// -----------------------------------------------------------------------------
// sc_rr_prio_picker
// Combinational rotating-priority picker: returns the first set bit of the
// eligible vector, searching upward from the pointer and wrapping N-1 -> 0.
// Ports:
//   i_elig    in  [N-1:0]   eligible requesters
//   i_ptr     in  [IW-1:0]  highest-priority index (must be < N)
//   o_onehot  out [N-1:0]   one-hot winner, zero when nothing eligible
//   o_idx     out [IW-1:0]  binary winner index, zero when nothing eligible
//   o_valid   out           at least one requester eligible
// -----------------------------------------------------------------------------
module sc_rr_prio_picker
   import sc_rr_slave_port_arbiter_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_elig,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   // Scan from the lowest priority upward so the last hit (the smallest
   // offset from the pointer) overrides earlier ones.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      for (int off = N - 1; off >= 0; off--) begin
         if (i_elig[sc_wrap_idx(int'(i_ptr), off, N)]) begin
            o_valid  = 1'b1;
            o_idx    = IW'(sc_wrap_idx(int'(i_ptr), off, N));
            o_onehot = N'(1) << sc_wrap_idx(int'(i_ptr), off, N);
         end
      end
   end

endmodule

// File: rtl/sc_rr_slave_port_arbiter.sv
// -----------------------------------------------------------------------------
// sc_rr_slave_port_arbiter
// Per-slave round-robin arbiter. Picks one decoding master, holds the grant
// until slave ack (or master abort), then rotates priority past the winner.
// Optional watchdog: define SC_RR_ARB_TIMEOUT_EN to force release after
// TIMEOUT grant cycles without ack (o_timeout pulses); otherwise o_timeout=0.
// Ports:
//   i_clk        in   clock (rising edge)
//   i_resetb     in   asynchronous active-low reset
//   i_ms_req     in   [N-1:0]    per-master request level
//   i_ms_addr    in   [32N-1:0]  per-master address, master k at [32k+:32]
//   i_sl_ack     in   single-cycle slave ack
//   o_grant      out  [N-1:0]    one-hot grant, zero when idle
//   o_grant_idx  out  [IW-1:0]   binary granted index, valid while o_busy
//   o_busy       out  slave port owned
//   o_timeout    out  one-cycle watchdog release pulse
// -----------------------------------------------------------------------------
module sc_rr_slave_port_arbiter
   import sc_rr_slave_port_arbiter_pkg::*;
#(
   parameter int          N_MASTERS = 2,
   parameter logic [31:0] SL_BASE   = SC_DEF_SL_BASE,
   parameter logic [31:0] SL_MASK   = SC_DEF_SL_MASK,
   parameter int          TIMEOUT   = 256,
   parameter int          IW        = $clog2(N_MASTERS)
) (
   input  logic                           i_clk,
   input  logic                           i_resetb,
   input  logic [N_MASTERS-1:0]           i_ms_req,
   input  logic [SC_ADDR_W*N_MASTERS-1:0] i_ms_addr,
   input  logic                           i_sl_ack,
   output logic [N_MASTERS-1:0]           o_grant,
   output logic [IW-1:0]                  o_grant_idx,
   output logic                           o_busy,
   output logic                           o_timeout
);

   if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT < 2) begin : g_bad_cfg
      $error("sc_rr_slave_port_arbiter: unsupported N_MASTERS/TIMEOUT");
   end

   sc_arb_state_t          r_state, w_state_next;
   logic [N_MASTERS-1:0]   r_grant, w_grant_next;
   logic [IW-1:0]          r_idx, w_idx_next;
   logic [IW-1:0]          r_ptr, w_ptr_next;
   logic                   w_timeout_next;
   logic                   w_release;
   logic                   w_wd_expired;

   logic [N_MASTERS-1:0]   w_elig;
   logic [N_MASTERS-1:0]   w_pick_onehot;
   logic [IW-1:0]          w_pick_idx;
   logic                   w_pick_valid;

   genvar gi;
   for (gi = 0; gi < N_MASTERS; gi++) begin : g_elig
      assign w_elig[gi] = i_ms_req[gi] &&
                          ((i_ms_addr[gi*SC_ADDR_W +: SC_ADDR_W] & SL_MASK) == SL_BASE);
   end

   sc_rr_prio_picker #(
      .N  (N_MASTERS),
      .IW (IW)
   ) u_picker (
      .i_elig   (w_elig),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx),
      .o_valid  (w_pick_valid)
   );

`ifdef SC_RR_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_wd_cnt;

   // Counts completed GRANT cycles; zero in IDLE so it starts fresh per grant.
   always_ff @(posedge i_clk or negedge i_resetb) begin
      if (!i_resetb)
         r_wd_cnt <= '0;
      else if (r_state == ST_IDLE)
         r_wd_cnt <= '0;
      else
         r_wd_cnt <= r_wd_cnt + CW'(1);
   end

   assign w_wd_expired = (r_wd_cnt == CW'(TIMEOUT - 1));
`else
   assign w_wd_expired = 1'b0;
`endif

   always_comb begin
      w_state_next   = r_state;
      w_grant_next   = r_grant;
      w_idx_next     = r_idx;
      w_ptr_next     = r_ptr;
      w_timeout_next = 1'b0;
      w_release      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Ack while idle is deliberately ignored.
            if (w_pick_valid) begin
               w_state_next = ST_GRANT;
               w_grant_next = w_pick_onehot;
               w_idx_next   = w_pick_idx;
            end
         end
         ST_GRANT: begin
            // Priority: ack beats abort beats watchdog.
            if (i_sl_ack || !i_ms_req[r_idx]) begin
               w_release = 1'b1;
            end else if (w_wd_expired) begin
               w_release      = 1'b1;
               w_timeout_next = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      if (w_release) begin
         w_state_next = ST_IDLE;
         w_grant_next = '0;
         w_ptr_next   = (r_idx == IW'(N_MASTERS - 1)) ? '0 : r_idx + IW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_resetb) begin
      if (!i_resetb) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_grant <= w_grant_next;
         r_idx   <= w_idx_next;
         r_ptr   <= w_ptr_next;
      end
   end

`ifdef SC_RR_ARB_TIMEOUT_EN
   logic r_timeout;
   always_ff @(posedge i_clk or negedge i_resetb) begin
      if (!i_resetb)
         r_timeout <= 1'b0;
      else
         r_timeout <= w_timeout_next;
   end
   assign o_timeout = r_timeout;
`else
   assign o_timeout = 1'b0;
`endif

   assign o_grant     = r_grant;
   assign o_grant_idx = r_idx;
   assign o_busy      = (r_state == ST_GRANT);

endmodule
